chunk_adder: RTL and testbench

Parametrised multi-cycle adder for two WIDTH-bit operands. It computes the sum CHUNK bits per clock and carries between chunks in a register, so long words can be added without a full-width ripple path. It is the sequential, handshaked successor to the team's combinational 4-bit ripple adder. It sits between a valid/ready producer and a valid/ready consumer and reports carry-out and signed overflow.

---
 rtl/chunk_adder.sv | 117 +++++++++++
 tb/tb_chunk_adder.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/chunk_adder.sv
// Multi-cycle valid/ready adder: CHUNK bits per clock with a registered inter-chunk carry.
// Optional subtract mode is enabled by defining CHUNK_ADDER_SUB_EN.
module chunk_adder #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef CHUNK_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int NCHUNK = (CHUNK >= 1) ? WIDTH / CHUNK : 1;
    localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCHUNK - 1);

    generate
        if (CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_bad_params
            $error("chunk_adder: CHUNK must be >= 1 and divide WIDTH");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t state_reg, state_next;

    // Operands and result viewed as NCHUNK slices so the chunk index selects directly.
    logic [NCHUNK-1:0][CHUNK-1:0] a_reg, b_reg, sum_reg;
    logic [IDX_W-1:0]             idx_reg;
    logic                         carry_reg, cout_reg, ovf_reg;

    logic             accept, last_chunk, carry_init, c_chunk;
    logic [CHUNK-1:0] s_chunk;
    logic [WIDTH-1:0] b_eff;

`ifdef CHUNK_ADDER_SUB_EN
    // a - b is a + ~b + 1; cin is ignored when subtracting.
    assign b_eff      = sub ? ~b : b;
    assign carry_init = sub ? 1'b1 : cin;
`else
    assign b_eff      = b;
    assign carry_init = cin;
`endif

    assign accept     = in_valid && in_ready;
    assign last_chunk = (idx_reg == LAST_IDX);
    assign {c_chunk, s_chunk} = {1'b0, a_reg[idx_reg]} + {1'b0, b_reg[idx_reg]}
                              + {{CHUNK{1'b0}}, carry_reg};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (accept) state_next = RUN;
            RUN:     if (last_chunk) state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_reg == IDLE) && !rst;
        out_valid = (state_reg == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_reg     <= '0;
            b_reg     <= '0;
            sum_reg   <= '0;
            idx_reg   <= '0;
            carry_reg <= 1'b0;
            cout_reg  <= 1'b0;
            ovf_reg   <= 1'b0;
        end else if (accept) begin
            a_reg     <= a;
            b_reg     <= b_eff;
            carry_reg <= carry_init;
            idx_reg   <= '0;
        end else if (state_reg == RUN) begin
            sum_reg[idx_reg] <= s_chunk;
            carry_reg        <= c_chunk;
            if (last_chunk) begin
                idx_reg  <= '0;
                cout_reg <= c_chunk;
                // Signed overflow: operands agree in sign but the result does not.
                ovf_reg  <= (a_reg[NCHUNK-1][CHUNK-1] == b_reg[NCHUNK-1][CHUNK-1])
                         && (s_chunk[CHUNK-1] != a_reg[NCHUNK-1][CHUNK-1]);
            end else begin
                idx_reg <= idx_reg + 1'b1;
            end
        end
    end

    assign sum  = sum_reg;
    assign cout = cout_reg;
    assign ovf  = ovf_reg;

endmodule

// File: tb/tb_chunk_adder.sv
// Self-checking bench for chunk_adder: three configurations (4/1, 16/4, 16/16), vector table plus
// scoreboard, and hand sequences for output hold and mid-operation reset.
module tb_chunk_adder;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [15:0] a_in, b_in;
    logic        cin_in, sub_in, out_ready_in;
    logic        in_valid_w [3];
    logic        in_ready_w [3];
    logic        out_valid_w[3];
    logic        cout_w     [3];
    logic        ovf_w      [3];
    logic [15:0] sum_w      [3];
    logic [3:0]  sum4;

    chunk_adder #(.WIDTH(4), .CHUNK(1)) u_w4c1 (
        .clk(clk), .rst(rst), .in_valid(in_valid_w[0]), .in_ready(in_ready_w[0]),
        .a(a_in[3:0]), .b(b_in[3:0]), .cin(cin_in),
`ifdef CHUNK_ADDER_SUB_EN
        .sub(sub_in),
`endif
        .out_valid(out_valid_w[0]), .out_ready(out_ready_in),
        .sum(sum4), .cout(cout_w[0]), .ovf(ovf_w[0]));
    assign sum_w[0] = {12'h000, sum4};

    chunk_adder #(.WIDTH(16), .CHUNK(4)) u_w16c4 (
        .clk(clk), .rst(rst), .in_valid(in_valid_w[1]), .in_ready(in_ready_w[1]),
        .a(a_in), .b(b_in), .cin(cin_in),
`ifdef CHUNK_ADDER_SUB_EN
        .sub(sub_in),
`endif
        .out_valid(out_valid_w[1]), .out_ready(out_ready_in),
        .sum(sum_w[1]), .cout(cout_w[1]), .ovf(ovf_w[1]));

    chunk_adder #(.WIDTH(16), .CHUNK(16)) u_w16c16 (
        .clk(clk), .rst(rst), .in_valid(in_valid_w[2]), .in_ready(in_ready_w[2]),
        .a(a_in), .b(b_in), .cin(cin_in),
`ifdef CHUNK_ADDER_SUB_EN
        .sub(sub_in),
`endif
        .out_valid(out_valid_w[2]), .out_ready(out_ready_in),
        .sum(sum_w[2]), .cout(cout_w[2]), .ovf(ovf_w[2]));

    typedef struct {
        int          sel;
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic        sub;
        logic [15:0] s;
        logic        co;
        logic        ov;
    } vec_t;

    vec_t vecs[$];
    vec_t sb[$];
    int   errors = 0;
    int   checks = 0;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input int sel, input logic [15:0] a, input logic [15:0] b,
                                input logic cin, input logic sub, input logic [15:0] s,
                                input logic co, input logic ov);
        vec_t v;
        v.sel = sel; v.a = a; v.b = b; v.cin = cin; v.sub = sub;
        v.s = s; v.co = co; v.ov = ov;
        return v;
    endfunction

    // Full-width reference: one wide add, no chunking.
    function automatic vec_t mk_model(input int sel, input logic [15:0] a, input logic [15:0] b,
                                      input logic cin, input logic sub);
        int          w;
        logic [15:0] mask, am, bb, s;
        logic [16:0] full;
        w    = (sel == 0) ? 4 : 16;
        mask = (w == 16) ? 16'hFFFF : 16'h000F;
        am   = a & mask;
        bb   = (sub ? ~b : b) & mask;
        full = {1'b0, am} + {1'b0, bb} + {16'h0000, (sub ? 1'b1 : cin)};
        s    = full[15:0] & mask;
        return mk(sel, am, b & mask, cin, sub, s, full[w],
                  (am[w-1] == bb[w-1]) && (s[w-1] != am[w-1]));
    endfunction

    task automatic run_vec(input vec_t v);
        int   cyc;
        int   n;
        vec_t e;
        n = (v.sel == 2) ? 1 : 4;
        a_in = v.a; b_in = v.b; cin_in = v.cin; sub_in = v.sub;
        out_ready_in = 1'b1;
        in_valid_w[v.sel] = 1'b1;
        chk("in_ready_idle", 32'(in_ready_w[v.sel]), 32'd1);
        tick;
        sb.push_back(v);
        in_valid_w[v.sel] = 1'b0;
        cyc = 0;
        while (!out_valid_w[v.sel] && cyc < 64) begin
            tick;
            cyc++;
            if (cyc == 1) chk("in_ready_busy", 32'(in_ready_w[v.sel]), 32'd0);
        end
        chk("latency", 32'(cyc), 32'(n));
        chk("out_valid", 32'(out_valid_w[v.sel]), 32'd1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("sum", 32'(sum_w[v.sel]), 32'(e.s));
            chk("cout", 32'(cout_w[v.sel]), 32'(e.co));
            chk("ovf", 32'(ovf_w[v.sel]), 32'(e.ov));
        end
        $display("txn sel=%0d a=%h b=%h cin=%b sub=%b -> sum=%h cout=%b ovf=%b lat=%0d",
                 v.sel, v.a, v.b, v.cin, v.sub, sum_w[v.sel], cout_w[v.sel], ovf_w[v.sel], cyc);
        tick;
        chk("consumed", 32'(out_valid_w[v.sel]), 32'd0);
        chk("in_ready_after", 32'(in_ready_w[v.sel]), 32'd1);
    endtask

    initial begin
        int cyc;
        int seen;
        rst = 1'b1;
        a_in = '0; b_in = '0; cin_in = 1'b0; sub_in = 1'b0; out_ready_in = 1'b0;
        for (int i = 0; i < 3; i++) in_valid_w[i] = 1'b0;
        tick;
        tick;
        chk("in_ready_in_rst", 32'(in_ready_w[1]), 32'd0);
        rst = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            chk("rst_in_ready", 32'(in_ready_w[i]), 32'd1);
            chk("rst_out_valid", 32'(out_valid_w[i]), 32'd0);
            chk("rst_sum", 32'(sum_w[i]), 32'd0);
            chk("rst_cout_ovf", {30'd0, cout_w[i], ovf_w[i]}, 32'd0);
        end

        vecs.push_back(mk(0, 16'h0001, 16'h0002, 1'b0, 1'b0, 16'h0003, 1'b0, 1'b0));
        vecs.push_back(mk(0, 16'h000F, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0));
        vecs.push_back(mk(0, 16'h0008, 16'h0008, 1'b1, 1'b0, 16'h0001, 1'b1, 1'b1));
        vecs.push_back(mk(1, 16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0));
        vecs.push_back(mk(1, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0));
        vecs.push_back(mk(1, 16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1));
        vecs.push_back(mk(2, 16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0));
        vecs.push_back(mk(2, 16'h7000, 16'h1000, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1));
`ifdef CHUNK_ADDER_SUB_EN
        vecs.push_back(mk(1, 16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0));
        vecs.push_back(mk(1, 16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1));
        vecs.push_back(mk(2, 16'h0003, 16'h0003, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0));
        for (int i = 0; i < 3; i++)
            vecs.push_back(mk_model(i, 16'($urandom), 16'($urandom), 1'($urandom), 1'b1));
`endif
        for (int i = 0; i < 6; i++)
            vecs.push_back(mk_model(i % 3, 16'($urandom), 16'($urandom), 1'($urandom), 1'b0));

        foreach (vecs[i]) run_vec(vecs[i]);

        // Result held while the consumer stalls; a new request is ignored.
        a_in = 16'h7FFF; b_in = 16'h0001; cin_in = 1'b0; sub_in = 1'b0;
        out_ready_in = 1'b0;
        in_valid_w[1] = 1'b1;
        tick;
        in_valid_w[1] = 1'b0;
        cyc = 0;
        while (!out_valid_w[1] && cyc < 64) begin
            tick;
            cyc++;
        end
        chk("hold_latency", 32'(cyc), 32'd4);
        in_valid_w[1] = 1'b1;
        a_in = 16'h1111; b_in = 16'h2222;
        for (int i = 0; i < 5; i++) begin
            chk("hold_sum", 32'(sum_w[1]), 32'h8000);
            chk("hold_flags", {30'd0, cout_w[1], ovf_w[1]}, 32'd1);
            chk("hold_valid", 32'(out_valid_w[1]), 32'd1);
            chk("hold_in_ready", 32'(in_ready_w[1]), 32'd0);
            tick;
        end
        $display("txn sel=1 a=7fff b=0001 held -> sum=%h cout=%b ovf=%b", sum_w[1], cout_w[1], ovf_w[1]);
        in_valid_w[1] = 1'b0;
        out_ready_in = 1'b1;
        tick;
        chk("hold_release", 32'(out_valid_w[1]), 32'd0);
        tick;
        chk("hold_no_accept", 32'(in_ready_w[1]), 32'd1);

        // Reset during the second RUN cycle aborts the operation.
        a_in = 16'h1234; b_in = 16'h1111; cin_in = 1'b0;
        in_valid_w[1] = 1'b1;
        tick;
        in_valid_w[1] = 1'b0;
        tick;
        rst = 1'b1;
        #1;
        chk("rst_forces_ready_low", 32'(in_ready_w[0]), 32'd0);
        tick;
        rst = 1'b0;
        #1;
        chk("abort_sum", 32'(sum_w[1]), 32'd0);
        chk("abort_flags", {30'd0, cout_w[1], ovf_w[1]}, 32'd0);
        chk("abort_valid", 32'(out_valid_w[1]), 32'd0);
        chk("abort_in_ready", 32'(in_ready_w[1]), 32'd1);
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            tick;
            if (out_valid_w[1]) seen++;
        end
        chk("abort_no_valid", 32'(seen), 32'd0);
        $display("txn sel=1 a=1234 b=1111 aborted by rst -> valid_pulses=%0d", seen);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
